// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART TX byte sender between NUM_REQ requesters.
// The TX has no busy output, so the block times each frame plus a guard gap itself.
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int INPUT_CLK  = 50000000,
    parameter int BAUD_RATE  = 230400,
    parameter int FRAME_BITS = 10,
    parameter int GAP_BITS   = 1
) (
    input  logic                       clk,
    input  logic                       kill,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [7:0]                 send_byte,
    output logic                       send_en,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);
    localparam int OW         = $clog2(NUM_REQ);
    localparam int FRAME_CLKS = (INPUT_CLK / BAUD_RATE) * (FRAME_BITS + GAP_BITS);
    localparam int CW         = $clog2(FRAME_CLKS);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         byte_q, byte_d;
    logic               en_q, en_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               found;
    logic [OW-1:0]      gnt;
    int                 idx;

    // first requester at or after ptr, wrapping past NUM_REQ-1 back to 0
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt   = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        en_d    = 1'b0;
        byte_d  = byte_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (found) begin
                state_d    = SEND;
                byte_d     = req_data[{gnt, 3'b000} +: 8];
                owner_d    = gnt;
                ack_d[gnt] = 1'b1;
                en_d       = 1'b1;
                ptr_d      = (gnt == OW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            end
            SEND: begin
                state_d = WAIT;
                cnt_d   = CW'(FRAME_CLKS - 1);
            end
            WAIT: begin
                state_d = (cnt_q == '0) ? IDLE : WAIT;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            state_q <= IDLE;
            ack_q   <= '0;
            byte_q  <= '0;
            en_q    <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            byte_q  <= byte_d;
            en_q    <= en_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack       = ack_q;
    assign send_byte = byte_q;
    assign send_en   = en_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and constrained-random checks of the round-robin UART TX scheduler.
module tb_uart_tx_scheduler;
    localparam int PERIOD = 2389;
    localparam int BUSY_CYCLES = 2388;

    logic        clk = 1'b0;
    logic        kill = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic [7:0]  send_byte;
    logic        send_en;
    logic        busy;
    logic [1:0]  owner;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_ack = 0;

    uart_tx_scheduler dut (
        .clk(clk), .kill(kill), .req(req), .req_data(req_data), .ack(ack),
        .send_byte(send_byte), .send_en(send_en), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (|ack) n_ack++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_en(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (send_en) begin
                at = cyc;
                return;
            end
        end
        chk("en_timeout", {31'd0, send_en}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic grant(input string tag, input int g, input logic [7:0] b);
        chk({tag, "_owner"}, owner, g);
        chk({tag, "_ack"}, ack, 32'd1 << g);
        chk({tag, "_byte"}, send_byte, b);
        chk({tag, "_busy"}, busy, 1);
    endtask

    function automatic int rr(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    initial begin
        int t0, t1, nb, base, mptr, g;
        logic [3:0] pr;
        logic [31:0] pd;
        logic pbusy, exp_en;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_en", send_en, 0);
        chk("rst_byte", send_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        kill = 1'b0;
        @(negedge clk);
        // 1: single request, latency and busy length
        req = 4'b0001;
        req_data = 32'h0000_00A5;
        t0 = cyc;
        wait_en(5, t1);
        chk("t1_latency", t1 - t0, 1);
        grant("t1", 0, 8'hA5);
        req = '0;
        nb = 0;
        while (busy && nb < 3000) begin
            nb++;
            @(negedge clk);
        end
        chk("t1_busy_len", nb, BUSY_CYCLES);
        // 2: all four held from a fresh reset
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        req = 4'b1111;
        req_data = 32'h1312_1110;
        t0 = 0;
        for (int i = 0; i < 5; i++) begin
            wait_en(3000, t1);
            grant("t2", i % 4, 8'h10 + 8'(i % 4));
            if (i > 0) chk("t2_period", t1 - t0, PERIOD);
            t0 = t1;
        end
        req = '0;
        wait_idle();
        // 3: grant 2, then wrap to 0 before 2 again
        @(negedge clk);
        req = 4'b0100;
        req_data = 32'h0033_0011;
        wait_en(5, t0);
        grant("t3a", 2, 8'h33);
        req = 4'b0101;
        wait_en(3000, t1);
        grant("t3b", 0, 8'h11);
        chk("t3_period", t1 - t0, PERIOD);
        wait_en(3000, t1);
        grant("t3c", 2, 8'h33);
        req = '0;
        wait_idle();
        // 4: kill in the middle of a frame
        @(negedge clk);
        #1 base = n_ack;
        req = 4'b1000;
        req_data = 32'h4400_2200;
        wait_en(5, t0);
        grant("t4a", 3, 8'h44);
        req = '0;
        repeat (300) @(negedge clk);
        kill = 1'b1;
        #1;
        chk("t4_kill_ack", ack, 0);
        chk("t4_kill_en", send_en, 0);
        chk("t4_kill_byte", send_byte, 0);
        chk("t4_kill_busy", busy, 0);
        chk("t4_kill_owner", owner, 0);
        @(negedge clk);
        kill = 1'b0;
        req = 4'b0010;
        wait_en(5, t1);
        grant("t4b", 1, 8'h22);
        req = '0;
        // 5: a req pulse on bit 3 during WAIT is forgotten
        repeat (100) @(negedge clk);
        req = 4'b1000;
        repeat (20) @(negedge clk);
        req = '0;
        wait_idle();
        repeat (20) @(negedge clk);
        #1;
        chk("t5_acks", n_ack - base, 2);
        chk("t5_busy", busy, 0);
        // 6: random requests against a round-robin reference, pointer is 2 here
        mptr = 2;
        pr = '0;
        pd = '0;
        pbusy = busy;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            exp_en = !pbusy && (pr != 0);
            chk("t6_proto", {29'd0, $onehot0(ack), send_en == (|ack), send_en}, {29'd0, 2'b11, exp_en});
            if (send_en && exp_en) begin
                g = rr(pr, mptr);
                chk("t6_owner", owner, g);
                chk("t6_ack", ack, 32'd1 << g);
                chk("t6_byte", send_byte, pd[8*g +: 8]);
                mptr = (g + 1) % 4;
            end
            pbusy = busy;
            pr = 4'($urandom_range(0, 15));
            pd = $urandom;
            req = pr;
            req_data = pd;
        end
        req = '0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
